ifm_window_fetch_ctrl: RTL and testbench
========================================

// Module: ifm_window_fetch_ctrl
// PURPOSE
//  Sequencer for the dual-port IFM feature-map memory (DATA_WIDTH x MEM_SIZE, 1-cycle registered read, per-port read/write enables).
//  On start, scans every KxK stride-1 conv window of an IMG_W x IMG_H map.
//  Issues two pixel reads per cycle (port A = pixel p, port B = pixel p+1) and streams the pairs to the conv engine over valid/ready.
//  When idle, it routes a host write interface onto port A so the image loader shares the memory.
// PARAMETERS
//  DATA_WIDTH  32   pixel width
//  IMG_W       28   map width
//  IMG_H       28   map height
//  K           5    kernel size; windows = (IMG_W-K+1)*(IMG_H-K+1)
//  ADDR_W      $clog2(IMG_W*IMG_H)  memory address width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous active-high reset
//  start        in   1        start scan; sampled only in IDLE
//  busy         out  1        high in FETCH/DRAIN
//  done         out  1        1-cycle pulse after final beat accepted
//  host_we      in   1        host write request; honoured only when busy=0
//  host_addr    in   ADDR_W   host write address
//  host_din     in   DATA_WIDTH host write data
//  host_wr_err  out  1        1-cycle pulse: host_we while busy (write dropped)
//  mem_addr_a   out  ADDR_W   port A address
//  mem_din_a    out  DATA_WIDTH port A write data (=host_din)
//  mem_we_a     out  1        port A write enable
//  mem_re_a     out  1        port A read enable
//  mem_addr_b   out  ADDR_W   port B address
//  mem_we_b     out  1        constant 0
//  mem_re_b     out  1        port B read enable
//  mem_dout_a   in   DATA_WIDTH port A read data
//  mem_dout_b   in   DATA_WIDTH port B read data
//  out_pix_a    out  DATA_WIDTH = mem_dout_a (combinational pass-through)
//  out_pix_b    out  DATA_WIDTH = mem_dout_b
//  out_b_vld    out  1        pixel B meaningful (0 on odd last beat of window)
//  out_valid    out  1        pair valid
//  out_ready    in   1        consumer accepts pair
//  out_win_last out  1        beat is last of its window
//  out_scan_last out 1        beat is last of entire scan
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (busy, done, valid, flags, enables, addresses); counters cleared.
//  - States: IDLE -start-> FETCH -last pair issued-> DRAIN -last beat accepted-> IDLE (done pulse same edge).
//  - start is ignored outside IDLE. Reset mid-scan aborts immediately, with no done pulse.
//  - Issue rule: in FETCH a read issues when (!out_valid || out_ready). An issue asserts mem_re_a, plus mem_re_b if p+1<K*K.
//    out_valid is set the next cycle. Data comes straight from the memory output registers.
//  - Stall: read enables stay low, so the memory holds its outputs. Addresses and flags are frozen, giving zero bubbles at full throughput.
//  - Beat accepted = out_valid && out_ready. In DRAIN, out_valid clears on acceptance.
//  - Window order: origin (r,c) row-major, c fastest. Pixel p -> (ky,kx) = (p/K, p%K).
//    addr = (r+ky)*IMG_W + c+kx, computed incrementally with adds only (no multiplier).
//  - Per window: ceil(K*K/2) beats. On the last beat with K*K odd, mem_re_b=0 and out_b_vld=0. Next window starts on the next issue.
//  - Wrap: kx=K-1 -> kx=0, ky++. Window end -> c++, and c=IMG_W-K -> c=0, r++.
//  - Flags out_win_last, out_scan_last and out_b_vld are registered alongside the issue, aligned with out_valid.
//  - Host port: in IDLE, mem_we_a=host_we and mem_addr_a=host_addr. Busy: mem_we_a=0 and host_wr_err pulses on host_we.
//  - start and host_we in the same IDLE cycle: the write is performed, the scan starts, and no error is raised.
// CONFIGURATION
//  - IFM_FETCH_PERF_EN defined: adds output stall_cnt [31:0]. It counts FETCH/DRAIN cycles with out_valid && !out_ready.
//    It clears on start acceptance and on rst, and holds its value after done.
//  - Undefined: no port and no counter logic.
// TESTING
//  - Default params, out_ready=1, start at cycle 0 -> first issue cycle 1, addrs A=0,B=1; beat 3 addrs 4,28.
//    Window 0 last beat A=116, out_b_vld=0, out_win_last=1.
//  - Full scan, no stall -> 576 windows x 13 = 7488 beats. Final A addr = 783 with out_scan_last=1.
//    done one cycle after that beat is accepted; beat count checked.
//  - Window origins: window 1 base addr 1, window 24 base 28, window 575 base 667 (checked on first beat of each).
//  - Random out_ready (50%) -> same 7488-beat data sequence as the no-stall run, no drops or dups.
//    Output stable while stalled. With IFM_FETCH_PERF_EN, stall_cnt = counted stall cycles.
//  - Host writes 784 words (data=addr) while idle, then scan -> streamed pixels equal addresses.
//    host_we during busy -> host_wr_err pulse, memory unchanged.
//  - rst at beat 100 -> next cycle busy=0, out_valid=0, no done. A new start restarts from addr 0.

Source files
------------

// File: rtl/ifm_window_fetch_ctrl_if.sv
// Host-write, dual-port memory and pixel-pair stream bundle for ifm_window_fetch_ctrl.
// master = the controller side, slave = memory/host/consumer side.
interface ifm_window_fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 10
);
    logic                  host_we;
    logic [ADDR_W-1:0]     host_addr;
    logic [DATA_WIDTH-1:0] host_din;

    logic [ADDR_W-1:0]     mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_din_a;
    logic                  mem_we_a;
    logic                  mem_re_a;
    logic [ADDR_W-1:0]     mem_addr_b;
    logic                  mem_we_b;
    logic                  mem_re_b;
    logic [DATA_WIDTH-1:0] mem_dout_a;
    logic [DATA_WIDTH-1:0] mem_dout_b;

    logic [DATA_WIDTH-1:0] out_pix_a;
    logic [DATA_WIDTH-1:0] out_pix_b;
    logic                  out_b_vld;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_win_last;
    logic                  out_scan_last;

    modport master (
        input  host_we, host_addr, host_din, mem_dout_a, mem_dout_b, out_ready,
        output mem_addr_a, mem_din_a, mem_we_a, mem_re_a, mem_addr_b, mem_we_b, mem_re_b,
               out_pix_a, out_pix_b, out_b_vld, out_valid, out_win_last, out_scan_last
    );

    modport slave (
        output host_we, host_addr, host_din, mem_dout_a, mem_dout_b, out_ready,
        input  mem_addr_a, mem_din_a, mem_we_a, mem_re_a, mem_addr_b, mem_we_b, mem_re_b,
               out_pix_a, out_pix_b, out_b_vld, out_valid, out_win_last, out_scan_last
    );
endinterface

// File: rtl/ifm_window_fetch_ctrl.sv
// Scans every KxK stride-1 window of the IFM, reading two pixels per issue and streaming the pairs.
// Optional IFM_FETCH_PERF_EN adds o_stall_cnt (busy cycles with out_valid && !out_ready).
module ifm_window_fetch_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int K          = 5,
    parameter int ADDR_W     = $clog2(IMG_W*IMG_H)
) (
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef IFM_FETCH_PERF_EN
    output logic [31:0] o_stall_cnt,
`endif
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_host_wr_err,
    ifm_window_fetch_ctrl_if.master bus
);
    localparam int KK = K*K;
    localparam int PW = $clog2(KK+2);
    localparam int KW = $clog2(K+1);
    localparam int CW = $clog2(IMG_W+1);
    localparam int RW = $clog2(IMG_H+1);
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] K_STEP = ADDR_W'(K);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_p;
    logic [KW-1:0]     r_kx;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_base;
    logic [CW-1:0]     r_c;
    logic [RW-1:0]     r_r;
    logic              r_valid, r_b_vld, r_win_last, r_scan_last, r_done, r_wr_err;

    logic              w_busy, w_issue, w_accept;
    logic              w_kx_last, w_kxb_last, w_b_vld, w_win_last, w_scan_last;
    logic [KW-1:0]     w_kx_b, w_kx_n;
    logic [ADDR_W-1:0] w_row_b, w_row_n, w_addr_a, w_addr_b;

    assign w_busy   = (r_state != IDLE);
    assign w_issue  = (r_state == FETCH) && (!r_valid || bus.out_ready);
    assign w_accept = r_valid && bus.out_ready;

    // Pixel B is one raster step past A inside the window; the next A is one more step.
    assign w_kx_last  = (r_kx == KW'(K-1));
    assign w_kx_b     = w_kx_last ? '0 : r_kx + KW'(1);
    assign w_row_b    = w_kx_last ? r_row + W_STEP : r_row;
    assign w_kxb_last = (w_kx_b == KW'(K-1));
    assign w_kx_n     = w_kxb_last ? '0 : w_kx_b + KW'(1);
    assign w_row_n    = w_kxb_last ? w_row_b + W_STEP : w_row_b;
    assign w_addr_a   = r_row + ADDR_W'(r_kx);
    assign w_addr_b   = w_row_b + ADDR_W'(w_kx_b);

    assign w_b_vld     = (r_p < PW'(KK-1));
    assign w_win_last  = (r_p >= PW'(KK-2));
    assign w_scan_last = w_win_last && (r_c == CW'(IMG_W-K)) && (r_r == RW'(IMG_H-K));

    assign o_busy        = w_busy;
    assign o_done        = r_done;
    assign o_host_wr_err = r_wr_err;

    // Host owns port A whenever the scan is not running.
    assign bus.mem_addr_a    = w_busy ? w_addr_a : bus.host_addr;
    assign bus.mem_din_a     = bus.host_din;
    assign bus.mem_we_a      = !w_busy && bus.host_we;
    assign bus.mem_re_a      = w_issue;
    assign bus.mem_addr_b    = w_busy ? w_addr_b : '0;
    assign bus.mem_we_b      = 1'b0;
    assign bus.mem_re_b      = w_issue && w_b_vld;
    assign bus.out_pix_a     = bus.mem_dout_a;
    assign bus.out_pix_b     = bus.mem_dout_b;
    assign bus.out_valid     = r_valid;
    assign bus.out_b_vld     = r_b_vld;
    assign bus.out_win_last  = r_win_last;
    assign bus.out_scan_last = r_scan_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_p         <= '0;
            r_kx        <= '0;
            r_row       <= '0;
            r_base      <= '0;
            r_c         <= '0;
            r_r         <= '0;
            r_valid     <= 1'b0;
            r_b_vld     <= 1'b0;
            r_win_last  <= 1'b0;
            r_scan_last <= 1'b0;
            r_done      <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_wr_err <= w_busy && bus.host_we;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state <= FETCH;
                    r_p     <= '0;
                    r_kx    <= '0;
                    r_row   <= '0;
                    r_base  <= '0;
                    r_c     <= '0;
                    r_r     <= '0;
                end
                FETCH: if (w_issue && w_scan_last) r_state <= DRAIN;
                DRAIN: if (w_accept) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            if (w_issue) begin
                r_valid     <= 1'b1;
                r_b_vld     <= w_b_vld;
                r_win_last  <= w_win_last;
                r_scan_last <= w_scan_last;
                if (w_win_last) begin
                    r_p  <= '0;
                    r_kx <= '0;
                    // Last column origin of a row: jumping K lands on the next row's first origin.
                    if (r_c == CW'(IMG_W-K)) begin
                        r_c    <= '0;
                        r_r    <= r_r + RW'(1);
                        r_base <= r_base + K_STEP;
                        r_row  <= r_base + K_STEP;
                    end else begin
                        r_c    <= r_c + CW'(1);
                        r_base <= r_base + ADDR_W'(1);
                        r_row  <= r_base + ADDR_W'(1);
                    end
                end else begin
                    r_p   <= r_p + PW'(2);
                    r_kx  <= w_kx_n;
                    r_row <= w_row_n;
                end
            end else if (w_accept) begin
                r_valid     <= 1'b0;
                r_b_vld     <= 1'b0;
                r_win_last  <= 1'b0;
                r_scan_last <= 1'b0;
            end
        end
    end

`ifdef IFM_FETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst)                          r_stall_cnt <= '0;
        else if (r_state == IDLE && i_start) r_stall_cnt <= '0;
        else if (w_busy && r_valid && !bus.out_ready)
                                            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign o_stall_cnt = r_stall_cnt;
`else
    // Stall counting not built.
`endif
endmodule

// File: tb/tb_ifm_window_fetch_ctrl.sv
// Bench for ifm_window_fetch_ctrl: behavioural memory, window-order model and directed scans.
module tb_ifm_window_fetch_ctrl;
    localparam int DW = 32, W = 28, H = 28, K = 5, AW = 10;
    localparam int KK = K*K, BPW = (KK+1)/2, NB = (W-K+1)*(H-K+1)*BPW, MEMN = W*H;

    logic clk = 1'b0;
    logic rst, start, busy, done, wr_err;
`ifdef IFM_FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif
    ifm_window_fetch_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus();

    ifm_window_fetch_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .K(K), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst),
`ifdef IFM_FETCH_PERF_EN
        .o_stall_cnt(stall_cnt),
`endif
        .i_start(start), .o_busy(busy), .o_done(done), .o_host_wr_err(wr_err), .bus(bus));

    initial forever #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural dual-port memory with registered reads.
    logic [31:0] tmem [0:MEMN-1];
    always @(posedge clk) begin
        if (bus.mem_re_a) bus.mem_dout_a <= (int'(bus.mem_addr_a) < MEMN) ? tmem[bus.mem_addr_a] : 32'hBAD0BAD0;
        if (bus.mem_re_b) bus.mem_dout_b <= (int'(bus.mem_addr_b) < MEMN) ? tmem[bus.mem_addr_b] : 32'hBAD0BAD0;
        if (bus.mem_we_a && int'(bus.mem_addr_a) < MEMN) tmem[bus.mem_addr_a] = bus.mem_din_a;
    end

    // Expected beat sequence straight from the window/pixel definitions.
    int ea[NB], eb[NB];
    bit ebv[NB], ewl[NB], esl[NB];
    int n_model = 0;
    task automatic build_model();
        for (int r = 0; r <= H-K; r++)
            for (int c = 0; c <= W-K; c++)
                for (int p = 0; p < KK; p += 2) begin
                    ea[n_model]  = (r + p/K)*W + c + p%K;
                    ebv[n_model] = (p+1 < KK);
                    eb[n_model]  = ebv[n_model] ? (r + (p+1)/K)*W + c + (p+1)%K : 0;
                    ewl[n_model] = (p+2 >= KK);
                    esl[n_model] = ewl[n_model] && r == H-K && c == W-K;
                    n_model++;
                end
    endtask

    // Monitor state
    bit mon_en = 0, rnd_rdy = 0, done_pend = 0, stall_prev = 0;
    int iss_idx = 0, beat_idx = 0, stall_tb = 0, first_iss_cyc = -1, start_cyc = 0;
    logic [63:0] prev_vec;
    int cap_a[NB], cap_b[NB];
    bit cap_wl[NB], cap_bv[NB], cap_sl[NB];

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("done_pulse", done, done_pend);
            done_pend = 0;
            if (bus.mem_we_b) chk("we_b_zero", bus.mem_we_b, 0);
            if (busy && bus.mem_we_a) chk("we_a_busy", bus.mem_we_a, 0);
            if (bus.mem_re_a) begin
                if (iss_idx == 0) first_iss_cyc = cyc;
                if (iss_idx >= NB) chk("extra_issue", iss_idx, NB - 1);
                else begin
                    chk("iss_addr_a", bus.mem_addr_a, ea[iss_idx]);
                    chk("iss_re_b", bus.mem_re_b, ebv[iss_idx]);
                    if (ebv[iss_idx]) chk("iss_addr_b", bus.mem_addr_b, eb[iss_idx]);
                    cap_a[iss_idx] = int'(bus.mem_addr_a);
                    cap_b[iss_idx] = int'(bus.mem_addr_b);
                end
                iss_idx++;
            end
            if (stall_prev)
                chk("stall_hold", {bus.out_valid, bus.out_b_vld, bus.out_win_last, bus.out_scan_last,
                                   bus.out_pix_a[29:0], bus.out_pix_b[29:0]}, prev_vec);
            if (bus.out_valid && bus.out_ready) begin
                if (beat_idx >= NB) chk("extra_beat", beat_idx, NB - 1);
                else begin
                    chk("pix_a", bus.out_pix_a, ea[beat_idx]);
                    if (ebv[beat_idx]) chk("pix_b", bus.out_pix_b, eb[beat_idx]);
                    chk("flags", {bus.out_b_vld, bus.out_win_last, bus.out_scan_last},
                        {ebv[beat_idx], ewl[beat_idx], esl[beat_idx]});
                    cap_bv[beat_idx] = bus.out_b_vld;
                    cap_wl[beat_idx] = bus.out_win_last;
                    cap_sl[beat_idx] = bus.out_scan_last;
                    if (beat_idx == NB - 1) done_pend = 1;
                end
                beat_idx++;
            end
            if (busy && bus.out_valid && !bus.out_ready) stall_tb++;
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_vec = {bus.out_valid, bus.out_b_vld, bus.out_win_last, bus.out_scan_last,
                        bus.out_pix_a[29:0], bus.out_pix_b[29:0]};
        end
    end

    task automatic arm_scan();
        iss_idx = 0; beat_idx = 0; stall_tb = 0; first_iss_cyc = -1;
        done_pend = 0; stall_prev = 0; mon_en = 1;
    endtask

    task automatic pulse_start(input bit with_we, input int wa, input int wd);
        @(posedge clk); #1;
        arm_scan();
        start = 1; start_cyc = cyc;
        bus.host_we = with_we; bus.host_addr = AW'(wa); bus.host_din = wd;
        @(posedge clk); #1;
        start = 0; bus.host_we = 0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int k = 0; k < 40000 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({nm, "_done_seen"}, seen, 1);
        @(negedge clk);
        chk({nm, "_beats"}, beat_idx, NB);
        chk({nm, "_issues"}, iss_idx, NB);
        chk({nm, "_idle"}, busy, 0);
        mon_en = 0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_idx < n && k < 40000) begin @(negedge clk); k++; end
        chk("beat_wait", beat_idx >= n, 1);
    endtask

    initial begin
        rst = 1; start = 0;
        bus.host_we = 0; bus.host_addr = '0; bus.host_din = '0;
        for (int i = 0; i < MEMN; i++) tmem[i] = 32'hFFFF_FFFF;
        build_model();
        chk("model_beats", n_model, 7488);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {busy, done, wr_err, bus.out_valid, bus.mem_re_a, bus.mem_re_b, bus.mem_we_a,
                         bus.mem_we_b, bus.out_b_vld, bus.out_win_last, bus.out_scan_last}, 0);
        chk("rst_addrs", {bus.mem_addr_a, bus.mem_addr_b}, 0);
`ifdef IFM_FETCH_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        @(posedge clk); #1; rst = 0;

        // Host load: data = address.
        for (int i = 0; i < MEMN; i++) begin
            @(posedge clk); #1;
            bus.host_we = 1; bus.host_addr = AW'(i); bus.host_din = i;
            @(negedge clk);
            chk("host_wr_route", {bus.mem_we_a, bus.mem_addr_a, bus.mem_din_a}, {1'b1, AW'(i), 32'(i)});
        end
        @(posedge clk); #1; bus.host_we = 0;
        @(negedge clk);
        chk("host_loaded", tmem[783], 783);

        // Scan 1: full throughput, plus a dropped host write mid-scan.
        rnd_rdy = 0;
        pulse_start(0, 0, 0);
        wait_beats(50);
        @(posedge clk); #1;
        bus.host_we = 1; bus.host_addr = AW'(5); bus.host_din = 32'hDEAD;
        @(posedge clk); #1; bus.host_we = 0;
        @(negedge clk); chk("wr_err_pulse", wr_err, 1);
        @(negedge clk); chk("wr_err_clear", wr_err, 0);
        wait_done("scan1");
        chk("mem_unchanged", tmem[5], 5);
        chk("first_issue_cyc", first_iss_cyc, start_cyc + 1);
        chk("b0_a", cap_a[0], 0);
        chk("b0_b", cap_b[0], 1);
        chk("b2_a", cap_a[2], 4);
        chk("b2_b", cap_b[2], 28);
        chk("w0_last_a", cap_a[12], 116);
        chk("w0_last_flags", {cap_bv[12], cap_wl[12]}, 2'b01);
        chk("win1_base", cap_a[13], 1);
        chk("win24_base", cap_a[24*13], 28);
        chk("win575_base", cap_a[575*13], 667);
        chk("final_a", cap_a[NB-1], 783);
        chk("scan_last_flags", {cap_sl[NB-2], cap_sl[NB-1]}, 2'b01);
`ifdef IFM_FETCH_PERF_EN
        chk("stall_cnt_nostall", stall_cnt, 0);
`endif

        // Scan 2: random ready; start and host write in the same idle cycle.
        @(posedge clk); #1;
        bus.host_we = 1; bus.host_addr = AW'(10); bus.host_din = 32'h77;
        @(posedge clk); #1; bus.host_we = 0;
        @(negedge clk); chk("pre_write", tmem[10], 32'h77);
        rnd_rdy = 1;
        pulse_start(1, 10, 10);
        @(negedge clk);
        chk("start_we_no_err", wr_err, 0);
        chk("start_we_written", tmem[10], 10);
        wait_done("scan2");
        rnd_rdy = 0;
        chk("stalls_seen", stall_tb > 100, 1);
`ifdef IFM_FETCH_PERF_EN
        chk("stall_cnt", stall_cnt, stall_tb);
        repeat (3) @(negedge clk);
        chk("stall_cnt_hold", stall_cnt, stall_tb);
`endif

        // Reset mid-scan, then restart from address 0.
        pulse_start(0, 0, 0);
        wait_beats(100);
        @(posedge clk); #1; mon_en = 0; rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("abort_state", {busy, bus.out_valid, done}, 0);
`ifdef IFM_FETCH_PERF_EN
        chk("abort_stall_cnt", stall_cnt, 0);
`endif
        repeat (3) begin @(negedge clk); chk("abort_no_done", {busy, done}, 0); end
        pulse_start(0, 0, 0);
        wait_done("scan3");
        chk("restart_a0", cap_a[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
